// File: rtl/enigma_pkg.sv
// Shared types, constants and mod-26 helpers for the Enigma rotor sequencer.
package enigma_pkg;

  localparam int CHAR_W = 5;
  localparam int ALPHA  = 26;

  typedef logic [CHAR_W-1:0] char_t;

  localparam char_t ALPHA_C = char_t'(ALPHA);

  typedef enum logic [1:0] {
    ROT0 = 2'd0,
    ROT1 = 2'd1,
    ROT2 = 2'd2,
    REFL = 2'd3
  } stage_e;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    ISSUE,
    CAPT,
    DONE
  } state_e;

  // Operands are expected below ALPHA; one conditional subtract then suffices.
  function automatic char_t add_mod26(input char_t a, input char_t b);
    logic [CHAR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, ALPHA_C}) s = s - {1'b0, ALPHA_C};
    return s[CHAR_W-1:0];
  endfunction

  function automatic char_t sub_mod26(input char_t a, input char_t b);
    logic [CHAR_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[CHAR_W]) d = d + {1'b0, ALPHA_C};
    return d[CHAR_W-1:0];
  endfunction

  // Pass order: rotors 0..2 forward, reflector, rotors 2..0 inverse.
  function automatic stage_e stage_of(input logic [2:0] pass);
    case (pass)
      3'd0:    return ROT0;
      3'd1:    return ROT1;
      3'd2:    return ROT2;
      3'd3:    return REFL;
      3'd4:    return ROT2;
      3'd5:    return ROT1;
      default: return ROT0;
    endcase
  endfunction

endpackage

// File: rtl/enigma_step_unit.sv
// Combinational rotor stepping (odometer with notches).
// ENIGMA_ROTOR_SEQ_DBLSTEP_EN selects the historical double-step of the middle rotor.
module enigma_step_unit
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4
) (
  input  logic [CHAR_W-1:0] pos0_i,
  input  logic [CHAR_W-1:0] pos1_i,
  input  logic [CHAR_W-1:0] pos2_i,
  output logic [CHAR_W-1:0] pos0_o,
  output logic [CHAR_W-1:0] pos1_o,
  output logic [CHAR_W-1:0] pos2_o
);

  localparam char_t N0 = char_t'(NOTCH0);
  localparam char_t N1 = char_t'(NOTCH1);

  logic carry1;
  logic carry2;

  // Carries are decided from the positions before this step.
  always_comb begin
    carry2 = (pos1_i == N1);
`ifdef ENIGMA_ROTOR_SEQ_DBLSTEP_EN
    carry1 = (pos0_i == N0) || carry2;
`else
    carry1 = (pos0_i == N0);
`endif
  end

  assign pos0_o = add_mod26(pos0_i, char_t'(1));
  assign pos1_o = carry1 ? add_mod26(pos1_i, char_t'(1)) : pos1_i;
  assign pos2_o = carry2 ? add_mod26(pos2_i, char_t'(1)) : pos2_i;

endmodule

// File: rtl/enigma_rotor_seq.sv
// Enigma sequencing controller: steps rotors, runs 7 serial lookups per character.
// Build option ENIGMA_ROTOR_SEQ_DBLSTEP_EN is consumed by enigma_step_unit.
module enigma_rotor_seq
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [CHAR_W-1:0] cfg_pos0,
  input  logic [CHAR_W-1:0] cfg_pos1,
  input  logic [CHAR_W-1:0] cfg_pos2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_err,
  output logic [CHAR_W-1:0] pos0,
  output logic [CHAR_W-1:0] pos1,
  output logic [CHAR_W-1:0] pos2,
  output logic              lu_req,
  output logic [1:0]        lu_stage,
  output logic              lu_inv,
  output logic [CHAR_W-1:0] lu_addr,
  input  logic [CHAR_W-1:0] lu_data
);

  state_e      state_q, state_d;
  char_t       pos0_q, pos0_d, pos1_q, pos1_d, pos2_q, pos2_d;
  char_t       c_q, c_d;
  logic [2:0]  pass_q, pass_d;
  char_t       out_char_q, out_char_d;
  logic        out_err_q, out_err_d;

  char_t       step0, step1, step2;
  stage_e      cur_stage;
  logic        cur_inv;
  char_t       cur_pos;
  char_t       issue_addr;
  char_t       capt_c;

  enigma_step_unit #(
    .NOTCH0 (NOTCH0),
    .NOTCH1 (NOTCH1)
  ) u_step (
    .pos0_i (pos0_q),
    .pos1_i (pos1_q),
    .pos2_i (pos2_q),
    .pos0_o (step0),
    .pos1_o (step1),
    .pos2_o (step2)
  );

  assign cur_stage = stage_of(pass_q);
  assign cur_inv   = (pass_q > 3'd3);

  always_comb begin
    unique case (cur_stage)
      ROT0:    cur_pos = pos0_q;
      ROT1:    cur_pos = pos1_q;
      ROT2:    cur_pos = pos2_q;
      default: cur_pos = '0;
    endcase
  end

  assign issue_addr = (cur_stage == REFL) ? c_q : add_mod26(c_q, cur_pos);
  assign capt_c     = (cur_stage == REFL) ? lu_data : sub_mod26(lu_data, cur_pos);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    pos0_d     = pos0_q;
    pos1_d     = pos1_q;
    pos2_d     = pos2_q;
    c_d        = c_q;
    pass_d     = pass_q;
    out_char_d = out_char_q;
    out_err_d  = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_load) begin
          // Adding zero folds 26..31 back into range.
          pos0_d = add_mod26(cfg_pos0, '0);
          pos1_d = add_mod26(cfg_pos1, '0);
          pos2_d = add_mod26(cfg_pos2, '0);
        end else if (in_valid) begin
          if (in_char >= ALPHA_C) begin
            out_char_d = in_char;
            out_err_d  = 1'b1;
            state_d    = DONE;
          end else begin
            c_d     = in_char;
            state_d = STEP;
          end
        end
      end
      STEP: begin
        pos0_d  = step0;
        pos1_d  = step1;
        pos2_d  = step2;
        pass_d  = 3'd0;
        state_d = ISSUE;
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        c_d = capt_c;
        if (pass_q == 3'd6) begin
          out_char_d = capt_c;
          out_err_d  = 1'b0;
          state_d    = DONE;
        end else begin
          pass_d  = pass_q + 3'd1;
          state_d = ISSUE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos0_q     <= '0;
      pos1_q     <= '0;
      pos2_q     <= '0;
      c_q        <= '0;
      pass_q     <= '0;
      out_char_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep all registers sampling pre-edge values.
      state_q    <= state_d;
      pos0_q     <= pos0_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      c_q        <= c_d;
      pass_q     <= pass_d;
      out_char_q <= out_char_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !cfg_load;
  assign out_valid = (state_q == DONE);
  assign out_char  = out_char_q;
  assign out_err   = out_err_q;
  assign pos0      = pos0_q;
  assign pos1      = pos1_q;
  assign pos2      = pos2_q;

  assign lu_req   = (state_q == ISSUE);
  assign lu_stage = lu_req ? cur_stage : ROT0;
  assign lu_inv   = lu_req && cur_inv;
  assign lu_addr  = lu_req ? issue_addr : '0;

endmodule
